writeback_unit: RTL and testbench

Writeback stage for the two-slot VLIW datapath. It accepts completed results from the ALU slot and the memory slot through valid/ready handshakes and buffers each slot in its own small FIFO. It drives the register file's two write ports (`alu_regWrite/alu_rd/alu_writeData` and `mem_regWrite/mem_rd/mem_writeData`) from registered outputs. When both slots target the same destination register, it serializes them so the memory result lands last.

---
 rtl/writeback_unit.sv | 146 ++++++++++++++
 tb/tb_writeback_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: per-slot FIFOs feed registered ALU/MEM register-file write ports; one-cycle accept-to-strobe latency.
// Each slot's ready drops when its FIFO is full; same-destination heads hold the MEM slot one cycle so MEM lands last.

module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  output logic                   push_rdy,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic                   head_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;

  // Ready ignores a same-cycle pop, so a full FIFO never accepts.
  assign push_rdy = (count < CW'(DEPTH)) && reset;
  assign push     = push_vld && push_rdy;
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_W-1:0]  alu_dst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_result,
  output logic              alu_regWrite,
  output logic [REG_W-1:0]  alu_rd,
  output logic [DATA_W-1:0] alu_writeData,
  output logic              mem_regWrite,
  output logic [REG_W-1:0]  mem_rd,
  output logic [DATA_W-1:0] mem_writeData,
  output logic [7:0]        collisions,
  output logic              idle
);
  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t                alu_in, mem_in, alu_head, mem_head;
  logic                  alu_head_vld, mem_head_vld;
  logic                  alu_pop, mem_pop, collide;
  logic [$clog2(DEPTH):0] alu_count, mem_count;

  assign alu_in = '{dst: alu_dst, data: alu_result};
  assign mem_in = '{dst: mem_dst, data: mem_result};

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (alu_valid),
    .push_rdy (alu_ready),
    .push_dat (alu_in),
    .pop      (alu_pop),
    .head_vld (alu_head_vld),
    .head_dat (alu_head),
    .count    (alu_count)
  );

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_mem_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (mem_valid),
    .push_rdy (mem_ready),
    .push_dat (mem_in),
    .pop      (mem_pop),
    .head_vld (mem_head_vld),
    .head_dat (mem_head),
    .count    (mem_count)
  );

  // MEM is younger in program order: on a shared destination it waits a cycle.
  assign collide = alu_head_vld && mem_head_vld && (alu_head.dst == mem_head.dst);
  assign alu_pop = alu_head_vld;
  assign mem_pop = mem_head_vld && !collide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_regWrite  <= 1'b0;
      alu_rd        <= '0;
      alu_writeData <= '0;
      mem_regWrite  <= 1'b0;
      mem_rd        <= '0;
      mem_writeData <= '0;
      collisions    <= '0;
    end else begin
      alu_regWrite <= alu_pop;
      mem_regWrite <= mem_pop;
      if (alu_pop) begin
        alu_rd        <= alu_head.dst;
        alu_writeData <= alu_head.data;
      end
      if (mem_pop) begin
        mem_rd        <= mem_head.dst;
        mem_writeData <= mem_head.data;
      end
      if (collide && (collisions != 8'hFF)) collisions <= collisions + 8'd1;
    end
  end

  assign idle = (alu_count == '0) && (mem_count == '0) && !alu_regWrite && !mem_regWrite;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: cycle table for basic/collision/streaming traffic, hand sequences for backpressure and reset.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [2:0]  alu_dst, mem_dst;
  logic [31:0] alu_result, mem_result;
  logic        alu_regWrite, mem_regWrite;
  logic [2:0]  alu_rd, mem_rd;
  logic [31:0] alu_writeData, mem_writeData;
  logic [7:0]  collisions;
  logic        idle;

  int checks = 0;
  int errors = 0;

  writeback_unit dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_dst       (alu_dst),
    .alu_result    (alu_result),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_dst       (mem_dst),
    .mem_result    (mem_result),
    .alu_regWrite  (alu_regWrite),
    .alu_rd        (alu_rd),
    .alu_writeData (alu_writeData),
    .mem_regWrite  (mem_regWrite),
    .mem_rd        (mem_rd),
    .mem_writeData (mem_writeData),
    .collisions    (collisions),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [2:0]  ad;
    logic [31:0] ar;
    logic        mv;
    logic [2:0]  md;
    logic [31:0] mr;
    logic        e_aw;
    logic [2:0]  e_ard;
    logic [31:0] e_awd;
    logic        e_mw;
    logic [2:0]  e_mrd;
    logic [31:0] e_mwd;
    logic [7:0]  e_col;
    logic        e_idle;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  function automatic vec_t mk(int av, int ad, int ar, int mv, int md, int mr,
                              int eaw, int eard, int eawd, int emw, int emrd, int emwd,
                              int ecol, int eidle);
    vec_t v;
    v.av = 1'(av);     v.ad = 3'(ad);     v.ar = 32'(ar);
    v.mv = 1'(mv);     v.md = 3'(md);     v.mr = 32'(mr);
    v.e_aw = 1'(eaw);  v.e_ard = 3'(eard); v.e_awd = 32'(eawd);
    v.e_mw = 1'(emw);  v.e_mrd = 3'(emrd); v.e_mwd = 32'(emwd);
    v.e_col = 8'(ecol); v.e_idle = 1'(eidle);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_dst = '0; alu_result = '0;
    mem_valid = 1'b0; mem_dst = '0; mem_result = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_sent, m_sent, a_got, m_got;
    logic a_fire, m_fire;

    // Expected values in each row are the outputs after that row's clock edge.
    //             ALU in         MEM in          ALU out         MEM out        col idle
    vec[0]  = mk(1, 0, 0,    1, 4, 256,   0, 0, 0,    0, 0, 0,     0, 0);
    vec[1]  = mk(0, 0, 0,    0, 0, 0,     1, 0, 0,    1, 4, 256,   0, 0);
    vec[2]  = mk(0, 0, 0,    0, 0, 0,     0, 0, 0,    0, 4, 256,   0, 1);
    vec[3]  = mk(1, 3, 'h10, 1, 3, 'h20,  0, 0, 0,    0, 4, 256,   0, 0);
    vec[4]  = mk(0, 0, 0,    0, 0, 0,     1, 3, 'h10, 0, 4, 256,   1, 0);
    vec[5]  = mk(0, 0, 0,    0, 0, 0,     0, 3, 'h10, 1, 3, 'h20,  1, 0);
    vec[6]  = mk(0, 0, 0,    0, 0, 0,     0, 3, 'h10, 0, 3, 'h20,  1, 1);
    vec[7]  = mk(1, 0, 0,    1, 4, 256,   0, 3, 'h10, 0, 3, 'h20,  1, 0);
    vec[8]  = mk(1, 1, 4,    1, 5, 258,   1, 0, 0,    1, 4, 256,   1, 0);
    vec[9]  = mk(1, 2, 8,    1, 6, 260,   1, 1, 4,    1, 5, 258,   1, 0);
    vec[10] = mk(1, 3, 12,   1, 7, 262,   1, 2, 8,    1, 6, 260,   1, 0);
    vec[11] = mk(1, 4, 16,   1, 0, 264,   1, 3, 12,   1, 7, 262,   1, 0);
    vec[12] = mk(1, 5, 20,   1, 1, 266,   1, 4, 16,   1, 0, 264,   1, 0);
    vec[13] = mk(1, 6, 24,   1, 2, 268,   1, 5, 20,   1, 1, 266,   1, 0);
    vec[14] = mk(1, 7, 28,   1, 3, 270,   1, 6, 24,   1, 2, 268,   1, 0);
    vec[15] = mk(1, 0, 32,   1, 4, 272,   1, 7, 28,   1, 3, 270,   1, 0);
    vec[16] = mk(1, 1, 36,   1, 5, 274,   1, 0, 32,   1, 4, 272,   1, 0);
    vec[17] = mk(0, 0, 0,    0, 0, 0,     1, 1, 36,   1, 5, 274,   1, 0);
    vec[18] = mk(0, 0, 0,    0, 0, 0,     0, 1, 36,   0, 5, 274,   1, 1);

    // Reset held with traffic offered.
    reset = 1'b0;
    alu_valid = 1'b1; alu_dst = 3'd2; alu_result = 32'h11;
    mem_valid = 1'b1; mem_dst = 3'd6; mem_result = 32'h22;
    repeat (3) @(negedge clk);
    chk("rst_alu_regWrite", 32'(alu_regWrite), 32'd0);
    chk("rst_mem_regWrite", 32'(mem_regWrite), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_collisions", 32'(collisions), 32'd0);
    chk("rst_alu_writeData", alu_writeData, 32'd0);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rel_alu_ready", 32'(alu_ready), 32'd1);
    chk("rel_mem_ready", 32'(mem_ready), 32'd1);
    chk("rel_no_strobe", 32'({alu_regWrite, mem_regWrite}), 32'd0);

    for (int k = 0; k < NV; k++) begin
      alu_valid = vec[k].av; alu_dst = vec[k].ad; alu_result = vec[k].ar;
      mem_valid = vec[k].mv; mem_dst = vec[k].md; mem_result = vec[k].mr;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_alu_regWrite", k), 32'(alu_regWrite), 32'(vec[k].e_aw));
      chk($sformatf("v%0d_alu_rd", k), 32'(alu_rd), 32'(vec[k].e_ard));
      chk($sformatf("v%0d_alu_writeData", k), alu_writeData, vec[k].e_awd);
      chk($sformatf("v%0d_mem_regWrite", k), 32'(mem_regWrite), 32'(vec[k].e_mw));
      chk($sformatf("v%0d_mem_rd", k), 32'(mem_rd), 32'(vec[k].e_mrd));
      chk($sformatf("v%0d_mem_writeData", k), mem_writeData, vec[k].e_mwd);
      chk($sformatf("v%0d_collisions", k), 32'(collisions), 32'(vec[k].e_col));
      chk($sformatf("v%0d_idle", k), 32'(idle), 32'(vec[k].e_idle));
      chk($sformatf("v%0d_readies", k), 32'({alu_ready, mem_ready}), 32'd3);
    end
    drive_idle();

    // Continuous collisions on dst 5: MEM backs up and drains once ALU stops.
    a_sent = 0; m_sent = 0; a_got = 0; m_got = 0;
    for (int c = 0; c < 30; c++) begin
      alu_valid = (a_sent < 6); alu_dst = 3'd5; alu_result = 32'hA0 + 32'(a_sent);
      mem_valid = (m_sent < 6); mem_dst = 3'd5; mem_result = 32'hB0 + 32'(m_sent);
      a_fire = alu_valid && alu_ready;
      m_fire = mem_valid && mem_ready;
      @(posedge clk);
      @(negedge clk);
      if (a_fire) a_sent++;
      if (m_fire) m_sent++;
      if (c == 1) chk("bp_mem_ready_low", 32'(mem_ready), 32'd0);
      if (alu_regWrite) begin
        chk($sformatf("bp_alu_data%0d", a_got), alu_writeData, 32'hA0 + 32'(a_got));
        chk($sformatf("bp_alu_rd%0d", a_got), 32'(alu_rd), 32'd5);
        a_got++;
      end
      if (mem_regWrite) begin
        chk($sformatf("bp_mem_data%0d", m_got), mem_writeData, 32'hB0 + 32'(m_got));
        chk($sformatf("bp_mem_rd%0d", m_got), 32'(mem_rd), 32'd5);
        chk("bp_mem_after_alu", 32'(alu_regWrite && alu_rd == mem_rd), 32'd0);
        m_got++;
      end
    end
    drive_idle();
    chk("bp_alu_count", 32'(a_got), 32'd6);
    chk("bp_mem_count", 32'(m_got), 32'd6);
    chk("bp_collisions", 32'(collisions), 32'd7);
    chk("bp_idle", 32'(idle), 32'd1);

    // Reset with two entries buffered.
    alu_valid = 1'b1; alu_dst = 3'd1; alu_result = 32'h55;
    mem_valid = 1'b1; mem_dst = 3'd1; mem_result = 32'h66;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    chk("mid_buffered_not_idle", 32'(idle), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_alu_writeData", alu_writeData, 32'd0);
    chk("mid_mem_writeData", mem_writeData, 32'd0);
    chk("mid_rd", 32'({alu_rd, mem_rd}), 32'd0);
    chk("mid_strobes", 32'({alu_regWrite, mem_regWrite}), 32'd0);
    chk("mid_collisions", 32'(collisions), 32'd0);
    chk("mid_readies", 32'({alu_ready, mem_ready}), 32'd0);
    chk("mid_idle", 32'(idle), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_rst_strobes%0d", c), 32'({alu_regWrite, mem_regWrite}), 32'd0);
      chk($sformatf("post_rst_idle%0d", c), 32'(idle), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
